// File: rtl/life_step_if.sv
// Bus bundle between the Game-of-Life generation engine and its surroundings:
// the start toggle, the two cell-RAM ports and the status/population outputs.
interface life_step_if #(
   parameter int WIDTH = 12
) ();
   logic                 start;
   logic [2*WIDTH-1:0]   read_addr;
   logic                 read_val;
   logic [2*WIDTH-1:0]   write_addr;
   logic                 write_en;
   logic                 write_val;
   logic                 busy;
   logic                 finish;
   logic [2*WIDTH-1:0]   population;

   // Engine side: drives addresses, write strobe and status.
   modport master (
      input  start,
      input  read_val,
      output read_addr,
      output write_addr,
      output write_en,
      output write_val,
      output busy,
      output finish,
      output population
   );

   // Environment side: provides the start toggle and the RAM read data.
   modport slave (
      output start,
      output read_val,
      input  read_addr,
      input  write_addr,
      input  write_en,
      input  write_val,
      input  busy,
      input  finish,
      input  population
   );
endinterface

// File: rtl/life_step.sv
// Game-of-Life generation engine. Walks the board cell by cell, reads the nine
// cells of each toroidal neighbourhood from the current-generation RAM, applies
// the B3/S23 rule and writes the result into the next-generation RAM.
module life_step #(
   parameter int P_PARAM_M = 5,
   parameter int P_PARAM_N = 5,
   parameter int WIDTH     = 12
) (
   input logic        clk,
   input logic        rst_n,
   life_step_if.master bus
);

   localparam int AW = 2 * WIDTH;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SET    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_WRITE  = 3'd4;
   localparam logic [2:0] S_HOLD   = 3'd5;

   localparam logic [WIDTH-1:0] LAST_ROW = WIDTH'(P_PARAM_M - 1);
   localparam logic [WIDTH-1:0] LAST_COL = WIDTH'(P_PARAM_N - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [2:0]       state;
   logic             prev_start;
   logic [WIDTH-1:0] row;
   logic [WIDTH-1:0] col;
   logic [3:0]       k;
   logic [3:0]       acc;
   logic             alive;
   logic [AW-1:0]    pop;

   logic [WIDTH-1:0] nb_row;
   logic [WIDTH-1:0] nb_col;
   logic [AW-1:0]    nb_addr;
   logic [AW-1:0]    cell_addr;
   logic             next_val;

   // Neighbour address for slot k, wrapping by comparison so nothing underflows.
   always_comb begin
      nb_row = row;
      nb_col = col;
      if (k < 4'd3) begin
         nb_row = (row == '0) ? LAST_ROW : row - ONE;
      end else if (k > 4'd5) begin
         nb_row = (row == LAST_ROW) ? '0 : row + ONE;
      end
      if (k == 4'd0 || k == 4'd3 || k == 4'd6) begin
         nb_col = (col == '0) ? LAST_COL : col - ONE;
      end else if (k == 4'd2 || k == 4'd5 || k == 4'd8) begin
         nb_col = (col == LAST_COL) ? '0 : col + ONE;
      end
      nb_addr   = AW'(nb_row) * AW'(P_PARAM_N) + AW'(nb_col);
      cell_addr = AW'(row) * AW'(P_PARAM_N) + AW'(col);
      next_val  = (acc == 4'd3) | (alive & (acc == 4'd2));
   end

   // Start-toggle detection, neighbourhood scan and result write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         prev_start     <= 1'b0;
         row            <= '0;
         col            <= '0;
         k              <= '0;
         acc            <= '0;
         alive          <= 1'b0;
         pop            <= '0;
         bus.read_addr  <= '0;
         bus.write_addr <= '0;
         bus.write_en   <= 1'b0;
         bus.write_val  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.finish     <= 1'b0;
         bus.population <= '0;
      end else begin
         prev_start <= bus.start;
         case (state)
            S_IDLE: begin
               if (bus.start != prev_start) begin
                  row        <= '0;
                  col        <= '0;
                  k          <= '0;
                  acc        <= '0;
                  pop        <= '0;
                  bus.finish <= 1'b0;
                  bus.busy   <= 1'b1;
                  state      <= S_SET;
               end
            end
            S_SET: begin
               bus.read_addr <= nb_addr;
               state         <= S_WAIT;
            end
            S_WAIT: begin
               state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               if (k == 4'd4) begin
                  alive <= bus.read_val;
               end else begin
                  acc <= acc + {3'b000, bus.read_val};
               end
               k <= k + 4'd1;
               if (k == 4'd8) begin
                  state <= S_WRITE;
               end else begin
                  state <= S_SET;
               end
            end
            S_WRITE: begin
               bus.write_addr <= cell_addr;
               bus.write_val  <= next_val;
               bus.write_en   <= 1'b1;
               pop            <= pop + AW'(next_val);
               state          <= S_HOLD;
            end
            S_HOLD: begin
               bus.write_en <= 1'b0;
               if (row == LAST_ROW && col == LAST_COL) begin
                  bus.population <= pop;
                  bus.busy       <= 1'b0;
                  bus.finish     <= 1'b1;
                  state          <= S_IDLE;
               end else begin
                  if (col == LAST_COL) begin
                     col <= '0;
                     row <= row + ONE;
                  end else begin
                     col <= col + ONE;
                  end
                  acc   <= '0;
                  k     <= '0;
                  state <= S_SET;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_life_step.sv
// Self-checking bench for life_step on a 5x5 torus. Expected write streams are
// queued when a generation is launched and compared as write strobes appear.
module tb_life_step;

   localparam int WIDTH  = 12;
   localparam int CELLS  = 25;
   localparam int CYCLES = 726;

   typedef struct {
      string       name;
      logic [24:0] board;
      logic [24:0] next_board;
      int          pop;
   } vec_t;

   typedef struct {
      int   addr;
      logic val;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic [24:0] cur_board;
   logic [24:0] next_board;
   wr_t         exp_q[$];
   int          checks;
   int          errors;
   int          write_count;
   vec_t        vecs[6];

   life_step_if #(.WIDTH(WIDTH)) bus ();

   life_step #(
      .P_PARAM_M(5),
      .P_PARAM_N(5),
      .WIDTH    (WIDTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read current RAM and write-only next RAM.
   always @(posedge clk) begin
      bus.read_val <= cur_board[bus.read_addr[4:0]];
      if (bus.write_en) next_board[bus.write_addr[4:0]] <= bus.write_val;
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Scoreboard: every write strobe is matched against the next queued expectation.
   always @(negedge clk) begin
      if (bus.write_en === 1'b1) begin
         write_count++;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected write", 1, 0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            checkOutput("write addr", longint'(bus.write_addr), e.addr);
            checkOutput($sformatf("write val @%0d", e.addr), longint'(bus.write_val), longint'(e.val));
         end
      end
   end

   // Independent reference: modulo-wrapped neighbour count with B3/S23.
   function automatic logic [24:0] refStep(input logic [24:0] b);
      logic [24:0] res;
      res = '0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            int n;
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) n += int'(b[((r + dr + 5) % 5) * 5 + ((c + dc + 5) % 5)]);
               end
            end
            res[r*5+c] = (n == 3) || (b[r*5+c] && n == 2);
         end
      end
      return res;
   endfunction

   task automatic applyStimulus(input logic [24:0] board, input logic [24:0] expected);
      cur_board   = board;
      write_count = 0;
      exp_q.delete();
      for (int i = 0; i < CELLS; i++) begin
         wr_t e;
         e.addr = i;
         e.val  = expected[i];
         exp_q.push_back(e);
      end
      @(negedge clk);
      bus.start = ~bus.start;
   endtask

   // Counts cycles from the detection edge (counted as 1) until finish, with
   // optional stray toggle or reset injection at a given cycle.
   task automatic waitFinish(input int ignore_at, input int reset_at, output int cycles);
      bit done;
      cycles = 0;
      done   = 0;
      while (!done && cycles < 2000) begin
         @(posedge clk);
         cycles++;
         #1;
         if (cycles == 1) begin
            checkOutput("busy after start", longint'(bus.busy), 1);
            checkOutput("finish cleared", longint'(bus.finish), 0);
         end
         if (cycles == ignore_at) bus.start = ~bus.start;
         if (cycles == reset_at) begin
            rst_n     = 1'b0;
            bus.start = 1'b0;
            done      = 1;
         end else if (bus.finish === 1'b1) begin
            done = 1;
         end
      end
   endtask

   task automatic runCase(input string name, input logic [24:0] board, input logic [24:0] expected,
                          input int exp_pop, input int ignore_at);
      int cycles;
      applyStimulus(board, expected);
      waitFinish(ignore_at, 0, cycles);
      checkOutput({name, " finish cycle"}, cycles, CYCLES);
      checkOutput({name, " population"}, longint'(bus.population), exp_pop);
      checkOutput({name, " write count"}, write_count, CELLS);
      checkOutput({name, " pending writes"}, exp_q.size(), 0);
      repeat (40) @(posedge clk);
      #1;
      checkOutput({name, " idle after run"}, longint'(bus.busy), 0);
      checkOutput({name, " no extra writes"}, write_count, CELLS);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, " read_addr"}, longint'(bus.read_addr), 0);
      checkOutput({name, " write_addr"}, longint'(bus.write_addr), 0);
      checkOutput({name, " write_en"}, longint'(bus.write_en), 0);
      checkOutput({name, " write_val"}, longint'(bus.write_val), 0);
      checkOutput({name, " busy"}, longint'(bus.busy), 0);
      checkOutput({name, " finish"}, longint'(bus.finish), 0);
      checkOutput({name, " population"}, longint'(bus.population), 0);
   endtask

   // Main sequence: reset, table of boards, then multi-cycle corner cases.
   initial begin
      logic [24:0] hblink;
      logic [24:0] vblink;
      logic [24:0] block;
      logic [24:0] rnd;
      logic [24:0] saved;
      int          cycles;
      int          writes_at_abort;

      checks      = 0;
      errors      = 0;
      write_count = 0;
      cur_board   = '0;
      next_board  = '0;
      bus.start   = 1'b0;
      rst_n       = 1'b0;

      hblink = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
      vblink = (25'd1 << 7)  | (25'd1 << 12) | (25'd1 << 17);
      block  = (25'd1 << 6)  | (25'd1 << 7)  | (25'd1 << 11) | (25'd1 << 12);

      vecs[0] = '{name: "empty",  board: 25'd0,  next_board: 25'd0,  pop: 0};
      vecs[1] = '{name: "blinker", board: hblink, next_board: vblink, pop: 3};
      vecs[2] = '{name: "wrap",
                  board: (25'd1 << 4) | (25'd1 << 0) | (25'd1 << 1),
                  next_board: (25'd1 << 20) | (25'd1 << 0) | (25'd1 << 5), pop: 3};
      vecs[3] = '{name: "block",  board: block,  next_board: block,  pop: 4};
      for (int i = 4; i < 6; i++) begin
         rnd = 25'($urandom);
         vecs[i].name       = $sformatf("random%0d", i - 4);
         vecs[i].board      = rnd;
         vecs[i].next_board = refStep(rnd);
         vecs[i].pop        = $countones(refStep(rnd));
      end

      #23;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkAllZero("idle after reset");

      for (int i = 0; i < 6; i++) begin
         $display("[TB] case %s", vecs[i].name);
         runCase(vecs[i].name, vecs[i].board, vecs[i].next_board, vecs[i].pop, 0);
      end

      $display("[TB] swapped-RAM blinker run");
      runCase("blinker fwd", hblink, vblink, 3, 0);
      saved = next_board;
      runCase("blinker back", saved, hblink, 3, 0);

      $display("[TB] stray start toggle at cycle 100");
      runCase("ignored toggle", 25'd0, 25'd0, 0, 100);

      $display("[TB] reset at cycle 300");
      applyStimulus(block, block);
      waitFinish(0, 300, cycles);
      #1;
      checkOutput("abort reached", cycles, 300);
      checkAllZero("mid-run reset");
      exp_q.delete();
      writes_at_abort = write_count;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      checkOutput("no writes after abort", write_count, writes_at_abort);
      checkOutput("finish after abort", longint'(bus.finish), 0);
      checkOutput("busy after abort", longint'(bus.busy), 0);
      runCase("fresh after abort", hblink, vblink, 3, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
